// File: rtl/icache_assoc.sv
// Set-associative (1- or 2-way) instruction cache with LRU replacement.
// One-cycle lookup; misses refill a full line word-by-word from memory.
module icache_assoc #(
  parameter int ADDR_W   = 18,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int WAYS     = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        rob_clear,
  input  logic        flush_in,
  output logic        hit,
  output logic [31:0] hit_inst,
  output logic        mem_ask,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  output logic        dbg_state
);

  localparam int SETS    = 1 << INDEX_W;
  localparam int WORDS   = 1 << OFFSET_W;
  localparam int TAG_LSB = INDEX_W + OFFSET_W + 2;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam logic [OFFSET_W-1:0] LAST_WORD = {OFFSET_W{1'b1}};

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  // Data and tag arrays carry no reset; the valid bits alone qualify them.
  logic [31:0]      data_q [WAYS][SETS][WORDS];
  logic [TAG_W-1:0] tag_q  [WAYS][SETS];

  logic [WAYS-1:0][SETS-1:0] valid_q, valid_d;
  logic [SETS-1:0]           lru_q, lru_d;

  state_t              state_q, state_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                hit_q, hit_d;
  logic [31:0]         inst_q, inst_d;
  logic                ask_q, ask_d;
  logic [31:0]         addr_q, addr_d;
  logic                vic_q, vic_d;
  logic [INDEX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]    tagl_q, tagl_d;

  logic data_we;
  logic tag_we;

  logic [OFFSET_W-1:0] pc_off;
  logic [INDEX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [WAYS-1:0]     way_hit;
  logic                any_hit;
  logic                hit_way;
  logic [31:0]         hit_word;
  logic                victim;
  logic                unused_pc_lsb;

  assign pc_off        = fetch_pc[OFFSET_W+1:2];
  assign pc_idx        = fetch_pc[TAG_LSB-1:OFFSET_W+2];
  assign pc_tag        = fetch_pc[ADDR_W-1:TAG_LSB];
  assign unused_pc_lsb = ^fetch_pc[1:0];

  assign hit       = hit_q;
  assign hit_inst  = inst_q;
  assign mem_ask   = ask_q;
  assign mem_addr  = addr_q;
  assign dbg_state = (state_q == S_REFILL);

  always_comb begin
    way_hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[w][pc_idx] && (tag_q[w][pc_idx] == pc_tag);
    end
    any_hit  = |way_hit;
    hit_way  = (WAYS == 2) ? !way_hit[0] : 1'b0;
    hit_word = data_q[hit_way][pc_idx][pc_off];
  end

  // Victim: first invalid way, way 0 preferred; otherwise the LRU way.
  always_comb begin
    if (!valid_q[0][pc_idx]) begin
      victim = 1'b0;
    end else if ((WAYS == 2) && !valid_q[WAYS-1][pc_idx]) begin
      victim = 1'b1;
    end else if (WAYS == 2) begin
      victim = lru_q[pc_idx];
    end else begin
      victim = 1'b0;
    end
  end

  // Memory handshake: mem_ask stays high for the whole refill; each mem_valid
  // cycle (with rdy_in high) consumes one word for the current mem_addr,
  // and mem_addr only advances after such a cycle.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    lru_d   = lru_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hit_d   = hit_q;
    inst_d  = inst_q;
    ask_d   = ask_q;
    addr_d  = addr_q;
    vic_d   = vic_q;
    idx_d   = idx_q;
    tagl_d  = tagl_q;
    data_we = 1'b0;
    tag_we  = 1'b0;
    if (rdy_in) begin
      hit_d  = 1'b0;
      inst_d = '0;
      case (state_q)
        S_IDLE: begin
          if (flush_in) begin
            valid_d = '0;
            lru_d   = '0;
          end
          if (fetch_valid && !rob_clear) begin
            if (any_hit && !flush_in) begin
              hit_d  = 1'b1;
              inst_d = hit_word;
              if (WAYS == 2) lru_d[pc_idx] = ~hit_way;
            end else begin
              vic_d   = flush_in ? 1'b0 : victim;
              idx_d   = pc_idx;
              tagl_d  = pc_tag;
              cnt_d   = '0;
              ask_d   = 1'b1;
              addr_d  = {fetch_pc[31:OFFSET_W+2], {(OFFSET_W+2){1'b0}}};
              state_d = S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (flush_in) pend_d = 1'b1;
          if (mem_valid) begin
            data_we = 1'b1;
            if (cnt_q == LAST_WORD) begin
              tag_we = 1'b1;
              valid_d[vic_q][idx_q] = 1'b1;
              if (WAYS == 2) lru_d[idx_q] = ~vic_q;
              // A flush seen during the refill also kills the line just filled.
              if (pend_q || flush_in) valid_d = '0;
              pend_d  = 1'b0;
              ask_d   = 1'b0;
              addr_d  = '0;
              state_d = S_IDLE;
            end else begin
              cnt_d  = cnt_q + 1'b1;
              addr_d = addr_q + 32'd4;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      lru_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      hit_q   <= 1'b0;
      inst_q  <= '0;
      ask_q   <= 1'b0;
      addr_q  <= '0;
      vic_q   <= 1'b0;
      idx_q   <= '0;
      tagl_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      lru_q   <= lru_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
      inst_q  <= inst_d;
      ask_q   <= ask_d;
      addr_q  <= addr_d;
      vic_q   <= vic_d;
      idx_q   <= idx_d;
      tagl_q  <= tagl_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (data_we) data_q[vic_q][idx_q][cnt_q] <= mem_inst;
    if (tag_we) tag_q[vic_q][idx_q] <= tagl_q;
  end

endmodule

// File: doc/icache_assoc.md
ICACHE_ASSOC -- requirements
Module: icache_assoc

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 18, meaning significant PC/memory address bits; bits above ADDR_W-1 are ignored.
REQ-002 The block SHALL have parameter INDEX_W, default 4, meaning log2 of the set count.
REQ-003 The block SHALL have parameter OFFSET_W, default 2, meaning log2 of the 32-bit words per line.
REQ-004 The block SHALL have parameter WAYS, default 2, meaning associativity, legal values 1 or 2.
REQ-005 Port clk_in, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 Port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port rdy_in, input, 1 bit: global enable; while low, all state and outputs SHALL hold.
REQ-008 Port fetch_valid, input, 1 bit: lookup request this cycle.
REQ-009 Port fetch_pc, input, 32 bits: lookup address; bits [1:0] are ignored.
REQ-010 Port rob_clear, input, 1 bit: pipeline flush; suppresses lookups.
REQ-011 Port flush_in, input, 1 bit: invalidate all lines (fence.i).
REQ-012 Port hit, output, 1 bit: hit_inst is valid.
REQ-013 Port hit_inst, output, 32 bits: fetched instruction.
REQ-014 Port mem_ask, output, 1 bit: word read request to the memory controller.
REQ-015 Port mem_addr, output, 32 bits: word address of the request.
REQ-016 Port mem_valid, input, 1 bit: mem_inst is valid for the current mem_addr.
REQ-017 Port mem_inst, input, 32 bits: returned word.

Function
REQ-018 Address split SHALL be: offset = pc[OFFSET_W+1:2]; index = pc[INDEX_W+OFFSET_W+1:OFFSET_W+2]; tag = pc[ADDR_W-1:INDEX_W+OFFSET_W+2].
REQ-019 Per set and way, the block SHALL store a valid bit, a tag and 2^OFFSET_W data words; per set, it SHALL store one LRU bit (unused when WAYS=1).
REQ-020 The FSM SHALL have states IDLE and REFILL; the reset state is IDLE.
REQ-021 In IDLE, fetch_valid=1 with rob_clear=0 and a tag match in any valid way SHALL give hit=1 and hit_inst=the addressed word on the next edge (1-cycle latency), and LRU[set] SHALL be set to point at the other way.
REQ-022 The lookup SHALL repeat every cycle fetch_valid stays high; each hit cycle SHALL produce a hit pulse.
REQ-023 Otherwise hit SHALL be 0 and hit_inst SHALL be 0 on the next edge, including the miss cycle, all REFILL cycles, rob_clear cycles and fetch_valid=0 cycles.
REQ-024 On an IDLE miss, victim selection SHALL be: the first invalid way (way 0 first); if none is invalid, the LRU way.
REQ-025 On an IDLE miss, the FSM SHALL latch the victim, index and tag, set mem_ask=1, set mem_addr={pc[31:OFFSET_W+2], 0...0} (line base), clear the word counter, and enter REFILL.
REQ-026 In REFILL, on each mem_valid the block SHALL write mem_inst into word[counter] of the victim way.
REQ-027 On a non-last word, the block SHALL advance the counter and mem_addr by 4, with mem_ask held at 1.
REQ-028 On the last word (counter = 2^OFFSET_W-1), the block SHALL write the tag, set valid=1, set LRU to the non-victim way, set mem_ask=0 and mem_addr=0, and return to IDLE; the refetch SHALL hit on the following lookup.
REQ-029 mem_addr SHALL change only after mem_valid; mem_ask SHALL stay high continuously for the whole refill.
REQ-030 rob_clear SHALL NOT abort a refill; the line SHALL complete and be installed.
REQ-031 flush_in in IDLE SHALL clear every valid bit and every LRU bit in one cycle; a lookup in the same cycle SHALL be treated as a miss.
REQ-032 flush_in during REFILL SHALL be latched as pending; at refill completion, all valid bits SHALL be cleared, including the just-filled line, and the pending flag SHALL be cleared.
REQ-033 mem_valid seen while in IDLE or while rdy_in=0 SHALL be ignored.

Reset
REQ-034 When rst_in is low, state=IDLE, all valid bits=0, all LRU bits=0, counter=0, pending flush=0, hit=0, hit_inst=0, mem_ask=0 and mem_addr=0 SHALL take effect immediately, without waiting for a clock edge.
REQ-035 Data and tag arrays SHALL NOT be reset.
REQ-036 Reset asserted mid-refill SHALL discard the partial line.

Verification (INDEX_W=4, OFFSET_W=2, WAYS=2)
REQ-037 Cold miss: fetch 0x00100 -> mem_ask=1 with mem_addr 0x100, 0x104, 0x108, 0x10C; after the 4th mem_valid mem_ask=0; fetch 0x00108 -> hit=1 with hit_inst equal to the 3rd returned word, 1 cycle later.
REQ-038 Replacement (set 0): fill 0x100, then 0x500, then hit 0x100, then fill 0x900 -> 0x500's way is evicted; 0x100 hits; 0x500 misses.
REQ-039 Flush: flush_in asserted during the 2nd word of the 0x100 refill -> refill completes; the next fetch of 0x100 misses and mem_ask=1 again.
REQ-040 rdy_in low for 3 cycles in REFILL with mem_valid pulsed -> counter and mem_addr unchanged; the words are not written.
REQ-041 rst_in driven low between edges during REFILL -> mem_ask=0 immediately; after release, fetch 0x100 misses.
REQ-042 rob_clear held for 1 cycle during a hit stream -> hit=0 in that cycle; a refill in progress still completes, and a later fetch of that line hits.
